// File: rtl/adder_stim_checker_if.sv
// Stimulus/check bus between adder_stim_checker (master) and its environment:
// run control and status, plus operand/result lines to the adder under test.
interface adder_stim_checker_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  logic              start;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  vec_cnt;
  logic [CNT_W-1:0]  err_cnt;
  logic [DATA_W-1:0] first_err_a;
  logic [DATA_W-1:0] first_err_b;
  logic              dut_rstn;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] sum;
  logic              carry;

  modport master (
    input  start, sum, carry,
    output busy, done, pass, vec_cnt, err_cnt, first_err_a, first_err_b,
           dut_rstn, a, b
  );

  modport slave (
    output start, sum, carry,
    input  busy, done, pass, vec_cnt, err_cnt, first_err_a, first_err_b,
           dut_rstn, a, b
  );
endinterface

// File: rtl/adder_stim_checker.sv
// Drives counter/LFSR operand pairs into an 8-bit adder, checks {carry,sum}
// against the exact 9-bit sum and reports vector/error counts for the run.
module adder_stim_checker #(
  parameter int unsigned NUM_VEC = 256,
  parameter int unsigned SETTLE  = 1
) (
  input logic                  tb_clk,
  input logic                  rst,
  adder_stim_checker_if.master bus
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TMR_W  = 4;
  localparam logic [DATA_W-1:0] LFSR_SEED = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE, ST_DUT_RST, ST_DRIVE, ST_WAIT, ST_CHECK, ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [DATA_W-1:0] index_q, index_d;
  logic [DATA_W-1:0] lfsr_q, lfsr_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [CNT_W-1:0]  vec_q, vec_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [DATA_W-1:0] ferr_a_q, ferr_a_d;
  logic [DATA_W-1:0] ferr_b_q, ferr_b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              dut_rstn_q, dut_rstn_d;
  logic              mismatch_c;
  logic [DATA_W:0]   ref_sum_c;

  assign ref_sum_c  = (DATA_W+1)'(a_q) + (DATA_W+1)'(b_q);
  assign mismatch_c = {bus.carry, bus.sum} != ref_sum_c;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    index_d  = index_q;
    lfsr_d   = lfsr_q;
    a_d      = a_q;
    b_d      = b_q;
    vec_d    = vec_q;
    err_d    = err_q;
    ferr_a_d = ferr_a_q;
    ferr_b_d = ferr_b_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d  = ST_DUT_RST;
          tmr_d    = TMR_W'(1);
          index_d  = '0;
          lfsr_d   = LFSR_SEED;
          vec_d    = '0;
          err_d    = '0;
          ferr_a_d = '0;
          ferr_b_d = '0;
        end
      end
      ST_DUT_RST: begin
        if (tmr_q == '0) state_d = ST_DRIVE;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      ST_DRIVE: begin
        a_d     = index_q;
        b_d     = lfsr_q;
        tmr_d   = TMR_W'(SETTLE - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tmr_q == '0) state_d = ST_CHECK;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      ST_CHECK: begin
        vec_d   = vec_q + CNT_W'(1);
        index_d = index_q + DATA_W'(1);
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        if (mismatch_c) begin
          if (err_q != '1) err_d = err_q + CNT_W'(1);
          // Capture only the first failing vector of the run
          if (err_q == '0) begin
            ferr_a_d = a_q;
            ferr_b_d = b_q;
          end
        end
        state_d = (vec_d == CNT_W'(NUM_VEC)) ? ST_DONE : ST_DRIVE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d     = (state_d == ST_DUT_RST) || (state_d == ST_DRIVE) ||
                 (state_d == ST_WAIT)    || (state_d == ST_CHECK);
    dut_rstn_d = (state_d != ST_DUT_RST);
    done_d     = (state_d == ST_DONE);
    pass_d     = done_d && (err_d == '0);
  end

  // State and output registers
  always_ff @(posedge tb_clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      index_q    <= '0;
      lfsr_q     <= LFSR_SEED;
      a_q        <= '0;
      b_q        <= '0;
      vec_q      <= '0;
      err_q      <= '0;
      ferr_a_q   <= '0;
      ferr_b_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      dut_rstn_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      index_q    <= index_d;
      lfsr_q     <= lfsr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      vec_q      <= vec_d;
      err_q      <= err_d;
      ferr_a_q   <= ferr_a_d;
      ferr_b_q   <= ferr_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      dut_rstn_q <= dut_rstn_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.vec_cnt     = vec_q;
  assign bus.err_cnt     = err_q;
  assign bus.first_err_a = ferr_a_q;
  assign bus.first_err_b = ferr_b_q;
  assign bus.dut_rstn    = dut_rstn_q;
  assign bus.a           = a_q;
  assign bus.b           = b_q;
endmodule

// File: tb/tb_adder_stim_checker.sv
// Directed bench for adder_stim_checker: short run with ideal and faulty
// adders, mid-run reset, restart from DONE, and a full 256-vector run.
module tb_adder_stim_checker;
  logic tb_clk = 1'b0;
  logic rst;
  logic stuck0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 tb_clk = ~tb_clk;

  adder_stim_checker_if bus4 ();
  adder_stim_checker_if bus256 ();

  adder_stim_checker #(.NUM_VEC(4), .SETTLE(1)) u_dut4 (
    .tb_clk (tb_clk),
    .rst    (rst),
    .bus    (bus4.master)
  );

  adder_stim_checker #(.NUM_VEC(256), .SETTLE(3)) u_dut256 (
    .tb_clk (tb_clk),
    .rst    (rst),
    .bus    (bus256.master)
  );

  // Adders under test; the small one can have sum[0] stuck at 0
  logic [8:0] s4, s256;
  always_comb begin
    s4          = 9'(bus4.a) + 9'(bus4.b);
    bus4.sum    = s4[7:0] & {7'h7f, ~stuck0};
    bus4.carry  = s4[8];
    s256        = 9'(bus256.a) + 9'(bus256.b);
    bus256.sum  = s256[7:0];
    bus256.carry = s256[8];
  end

  // Operand-pair log, adder-reset cycle count and carry-vector detection
  logic [15:0] ab_log[$];
  logic [15:0] prev_ab = '0;
  int          rstn_lo = 0;
  bit          saw_carry = 1'b0;
  always @(negedge tb_clk) begin
    if (bus4.busy && ({bus4.a, bus4.b} != prev_ab)) ab_log.push_back({bus4.a, bus4.b});
    prev_ab = {bus4.a, bus4.b};
    if (bus4.busy && !bus4.dut_rstn) rstn_lo++;
    if (bus256.busy && ((9'(bus256.a) + 9'(bus256.b)) > 9'd255)) saw_carry = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic raise_start(input bit sel);
    @(negedge tb_clk);
    if (sel) bus256.start = 1'b1;
    else     bus4.start   = 1'b1;
    @(posedge tb_clk);
    #1;
  endtask

  // Counts rising edges after the start-sampling edge until done is seen
  task automatic wait_done(input bit sel, input int limit, input int drop_at, output int cycles);
    cycles = 0;
    while (cycles < limit) begin
      @(posedge tb_clk);
      cycles++;
      if (cycles == drop_at) begin
        #1;
        bus4.start   = 1'b0;
        bus256.start = 1'b0;
      end
      @(negedge tb_clk);
      if ((sel ? bus256.done : bus4.done) == 1'b1) break;
    end
  endtask

  logic [15:0] exp_ab [4];
  int          cyc;
  bit          found;

  initial begin
    exp_ab[0] = 16'h0001;
    exp_ab[1] = 16'h0102;
    exp_ab[2] = 16'h0204;
    exp_ab[3] = 16'h0308;
    stuck0       = 1'b0;
    bus4.start   = 1'b0;
    bus256.start = 1'b0;
    rst          = 1'b1;

    repeat (2) @(negedge tb_clk);
    check_eq("rst_busy",     32'(bus4.busy),        32'd0);
    check_eq("rst_done",     32'(bus4.done),        32'd0);
    check_eq("rst_pass",     32'(bus4.pass),        32'd0);
    check_eq("rst_ab",       32'({bus4.a, bus4.b}), 32'd0);
    check_eq("rst_vec",      32'(bus4.vec_cnt),     32'd0);
    check_eq("rst_err",      32'(bus4.err_cnt),     32'd0);
    check_eq("rst_dut_rstn", 32'(bus4.dut_rstn),    32'd0);
    rst = 1'b0;
    @(negedge tb_clk);
    check_eq("dut_rstn_release", 32'(bus4.dut_rstn), 32'd1);

    // Run A: ideal adder, single-cycle start pulse
    rstn_lo = 0;
    ab_log.delete();
    raise_start(1'b0);
    wait_done(1'b0, 200, 1, cyc);
    check_eq("a_cycles",  32'(cyc),            32'd14);
    check_eq("a_done",    32'(bus4.done),      32'd1);
    check_eq("a_pass",    32'(bus4.pass),      32'd1);
    check_eq("a_busy",    32'(bus4.busy),      32'd0);
    check_eq("a_vec",     32'(bus4.vec_cnt),   32'd4);
    check_eq("a_err",     32'(bus4.err_cnt),   32'd0);
    check_eq("a_ferr",    32'({bus4.first_err_a, bus4.first_err_b}), 32'd0);
    check_eq("a_rstn_lo", 32'(rstn_lo),        32'd2);
    check_eq("a_nvec",    32'(ab_log.size()),  32'd4);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("a_ab%0d", i), 32'(ab_log[i]), 32'(exp_ab[i]));
    repeat (3) @(negedge tb_clk);
    check_eq("a_hold_done", 32'(bus4.done),    32'd1);
    check_eq("a_hold_vec",  32'(bus4.vec_cnt), 32'd4);

    // Run B: faulty adder, started from DONE with start held high
    stuck0  = 1'b1;
    rstn_lo = 0;
    ab_log.delete();
    raise_start(1'b0);
    @(negedge tb_clk);
    check_eq("b_done_clr", 32'(bus4.done),     32'd0);
    check_eq("b_pass_clr", 32'(bus4.pass),     32'd0);
    check_eq("b_err_clr",  32'(bus4.err_cnt),  32'd0);
    check_eq("b_busy",     32'(bus4.busy),     32'd1);
    check_eq("b_dut_rstn", 32'(bus4.dut_rstn), 32'd0);
    wait_done(1'b0, 200, 5, cyc);
    check_eq("b_cycles",  32'(cyc),              32'd14);
    check_eq("b_done",    32'(bus4.done),        32'd1);
    check_eq("b_pass",    32'(bus4.pass),        32'd0);
    check_eq("b_vec",     32'(bus4.vec_cnt),     32'd4);
    check_eq("b_err",     32'(bus4.err_cnt),     32'd3);
    check_eq("b_ferr_a",  32'(bus4.first_err_a), 32'h00);
    check_eq("b_ferr_b",  32'(bus4.first_err_b), 32'h01);
    check_eq("b_rstn_lo", 32'(rstn_lo),          32'd2);
    check_eq("b_ab0",     32'(ab_log[0]),        32'h0001);

    // Run C: reset during WAIT of vector 2, then restart
    stuck0 = 1'b0;
    raise_start(1'b0);
    bus4.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge tb_clk);
      if (bus4.busy && bus4.a == 8'd2) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("c_reach_v2", 32'(found),        32'd1);
    check_eq("c_vec_pre",  32'(bus4.vec_cnt), 32'd2);
    rst = 1'b1;
    #1;
    check_eq("c_busy",     32'(bus4.busy),        32'd0);
    check_eq("c_done",     32'(bus4.done),        32'd0);
    check_eq("c_ab",       32'({bus4.a, bus4.b}), 32'd0);
    check_eq("c_vec",      32'(bus4.vec_cnt),     32'd0);
    check_eq("c_dut_rstn", 32'(bus4.dut_rstn),    32'd0);
    @(negedge tb_clk);
    rst = 1'b0;
    @(negedge tb_clk);
    ab_log.delete();
    raise_start(1'b0);
    wait_done(1'b0, 200, 1, cyc);
    check_eq("c_cycles", 32'(cyc),       32'd14);
    check_eq("c_ab0",    32'(ab_log[0]), 32'h0001);
    check_eq("c_pass",   32'(bus4.pass), 32'd1);

    // Run D: full 256-vector run with SETTLE=3
    saw_carry = 1'b0;
    raise_start(1'b1);
    wait_done(1'b1, 3000, 1, cyc);
    check_eq("d_cycles", 32'(cyc),             32'd1282);
    check_eq("d_done",   32'(bus256.done),     32'd1);
    check_eq("d_pass",   32'(bus256.pass),     32'd1);
    check_eq("d_vec",    32'(bus256.vec_cnt),  32'd256);
    check_eq("d_err",    32'(bus256.err_cnt),  32'd0);
    check_eq("d_carry",  32'(saw_carry),       32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_stim_checker.md
ADDER_STIM_CHECKER -- requirements
Module: adder_stim_checker

Interface
REQ-001 Parameter NUM_VEC, default 256: vectors per run; legal range 1..65535.
REQ-002 Parameter SETTLE, default 1: cycles between driving operands and sampling the result; legal range 1..15.
REQ-003 tb_clk  in  1  clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  run request, sampled on the rising edge.
REQ-006 dut_rstn  out  1  active-low reset to the adder under test.
REQ-007 a  out  8  operand A to the adder.
REQ-008 b  out  8  operand B to the adder.
REQ-009 sum  in  8  adder sum.
REQ-010 carry  in  1  adder carry-out.
REQ-011 busy  out  1  high while a run is in progress.
REQ-012 done  out  1  high from run completion until the next start or rst.
REQ-013 pass  out  1  high only when done=1 and err_cnt=0.
REQ-014 vec_cnt  out  16  vectors checked in the current run.
REQ-015 err_cnt  out  16  mismatches in the current run; saturates at 0xFFFF.
REQ-016 first_err_a / first_err_b  out  8 each  operands of the first mismatching vector; 0 if none.

Function
REQ-017 FSM states are IDLE, DUT_RST, DRIVE, WAIT, CHECK and DONE.
REQ-018 IDLE or DONE with start=1 shall enter DUT_RST and clear vec_cnt, err_cnt, first_err_*, done and pass; index=0; LFSR=0x01.
REQ-019 start shall be ignored in DUT_RST, DRIVE, WAIT and CHECK.
REQ-020 DUT_RST lasts exactly 2 cycles with dut_rstn=0, then goes to DRIVE; dut_rstn=1 in all other states.
REQ-021 DRIVE lasts 1 cycle and registers a=index[7:0], b=LFSR; a and b shall hold until the next DRIVE.
REQ-022 WAIT lasts exactly SETTLE cycles, then goes to CHECK.
REQ-023 CHECK lasts 1 cycle: compare {carry,sum} against the 9-bit zero-extended a+b.
REQ-024 On a CHECK mismatch, err_cnt increments with saturation; on the first mismatch only, capture a and b into first_err_*.
REQ-025 Every CHECK shall increment vec_cnt and index and advance the LFSR: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-026 After CHECK: if vec_cnt (post-increment) = NUM_VEC, go to DONE; otherwise go to DRIVE.
REQ-027 Per-vector cost is SETTLE+2 cycles; a run is 2 + NUM_VEC*(SETTLE+2) cycles from start sample to done=1.
REQ-028 busy=1 in DUT_RST, DRIVE, WAIT and CHECK; busy=0 in IDLE and DONE.
REQ-029 done=1 and valid pass shall both be asserted in the first DONE cycle; vec_cnt, err_cnt and first_err_* hold in DONE.
REQ-030 index wraps modulo 256 for NUM_VEC > 256.

Reset
REQ-031 rst=1 shall immediately force IDLE, without waiting for a clock edge.
REQ-032 rst=1 shall force busy=0, done=0, pass=0, a=0, b=0, all counters and first_err_*=0, LFSR=0x01 and dut_rstn=0.
REQ-033 dut_rstn returns to 1 on the first rising edge after rst deasserts.
REQ-034 rst asserted mid-run shall abandon the run; the next start restarts from vector 0.

Verification
REQ-035 Ideal adder, NUM_VEC=4, SETTLE=1, 1-cycle start pulse -> (a,b) = (00,01), (01,02), (02,04), (03,08); done after 14 cycles; vec_cnt=4, err_cnt=0, pass=1.
REQ-036 Adder with sum[0] stuck at 0, NUM_VEC=4 -> err_cnt=3 (vectors 0, 1 and 3), first_err_a=00, first_err_b=01, pass=0, done=1.
REQ-037 Ideal adder, NUM_VEC=256, SETTLE=3 -> vec_cnt=256, pass=1 in 1282 cycles; include a carry-out vector and check it passes.
REQ-038 rst pulse during WAIT of vector 2 -> outputs at reset values within the same cycle; a later start gives (a,b)=(00,01) first.
REQ-039 start held high during a run -> ignored; start in DONE -> err_cnt and done clear, DUT_RST re-entered, dut_rstn low for 2 cycles.
